// File: rtl/tdm_demux.sv
// Receive end of a mux-based TDM link: gathers N slot words into a shadow bank
// and publishes each complete frame atomically. Optional parity check: TDM_PARITY_EN.
module tdm_demux #(
  parameter int SELW = 2,
  parameter int W    = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   En,
  input  logic                   Sync,
  input  logic [W-1:0]           Din,
`ifdef TDM_PARITY_EN
  input  logic                   Par,
  output logic                   ParErr,
`endif
  output logic [(2**SELW)*W-1:0] Q,
  output logic [SELW-1:0]        Sel,
  output logic                   FrameValid,
  output logic                   Locked,
  output logic                   SyncErr
);

  localparam int N = 2 ** SELW;
  localparam logic [SELW-1:0] LAST_SLOT = SELW'(N - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SELW-1:0]        sel_q, sel_d;
  logic [(N-1)*W-1:0]     shadow_q, shadow_d;
  logic [N*W-1:0]         frame_q, frame_d;
  logic                   fv_q, fv_d;
  logic                   locked_q, locked_d;
  logic                   serr_q, serr_d;
  logic                   frame_bad_q, frame_bad_d;
  logic                   word_bad_s;
`ifdef TDM_PARITY_EN
  logic                   perr_q, perr_d;

  // Odd parity: the word plus its parity bit must hold an odd number of ones.
  function automatic logic odd_parity_bad(input logic [W-1:0] data, input logic par);
    return (^{data, par}) != 1'b1;
  endfunction
`endif

  // Per-word parity verdict; constant clean when parity checking is not built in.
  always_comb begin
    word_bad_s = 1'b0;
`ifdef TDM_PARITY_EN
    if (En) begin
      word_bad_s = odd_parity_bad(Din, Par);
    end else begin
      word_bad_s = 1'b0;
    end
`endif
  end

  // Slot sequencing, shadow fill and frame publication.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    frame_bad_d = frame_bad_q;
    fv_d        = 1'b0;
    serr_d      = 1'b0;
`ifdef TDM_PARITY_EN
    perr_d      = word_bad_s;
`endif
    if (En) begin
      case (state_q)
        HUNT: begin
          if (Sync) begin
            shadow_d[W-1:0] = Din;
            sel_d           = SELW'(1);
            frame_bad_d     = word_bad_s;
            state_d         = LOCKED;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (Sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and resyncs.
            serr_d          = (sel_q != '0);
            shadow_d[W-1:0] = Din;
            sel_d           = SELW'(1);
            frame_bad_d     = word_bad_s;
          end else if (sel_q == '0) begin
            serr_d  = 1'b1;
            sel_d   = '0;
            state_d = HUNT;
          end else if (sel_q == LAST_SLOT) begin
            sel_d = '0;
            if (!(frame_bad_q || word_bad_s)) begin
              frame_d = {Din, shadow_q};
              fv_d    = 1'b1;
            end else begin
              frame_d = frame_q;
            end
          end else begin
            for (int k = 1; k < N - 1; k++) begin
              if (sel_q == SELW'(k)) begin
                shadow_d[k*W +: W] = Din;
              end else begin
                shadow_d[k*W +: W] = shadow_q[k*W +: W];
              end
            end
            sel_d       = sel_q + SELW'(1);
            frame_bad_d = frame_bad_q | word_bad_s;
          end
        end
        default: begin
          state_d = HUNT;
          sel_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= HUNT;
      sel_q       <= '0;
      shadow_q    <= '0;
      frame_q     <= '0;
      frame_bad_q <= 1'b0;
      fv_q        <= 1'b0;
      locked_q    <= 1'b0;
      serr_q      <= 1'b0;
`ifdef TDM_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      frame_bad_q <= frame_bad_d;
      fv_q        <= fv_d;
      locked_q    <= locked_d;
      serr_q      <= serr_d;
`ifdef TDM_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign Q          = frame_q;
  assign Sel        = sel_q;
  assign FrameValid = fv_q;
  assign Locked     = locked_q;
  assign SyncErr    = serr_q;
`ifdef TDM_PARITY_EN
  assign ParErr     = perr_q;
`endif

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a mux-based TDM link, where a transmitter's selector walks through N channels onto one shared data line.
- Takes one W-bit word per valid slot, together with a frame-sync marker on channel 0.
- Distributes the words into N per-channel registers.
- Publishes a complete frame atomically, with a one-cycle FrameValid pulse.
- Sits between the serial link and the per-channel consumers.

Parameters:
SELW, 2, slot-select width; channel count N = 2**SELW
W, 8, data word width per channel

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
En  input  1  current cycle carries a valid slot word
Sync  input  1  marks the slot word as channel 0; qualified by En
Din  input  W  slot data word
Q  output  N*W  published frame; channel k at Q[k*W +: W]
Sel  output  SELW  next expected slot index
FrameValid  output  1  one-cycle pulse: Q has just been updated
Locked  output  1  1 while in LOCKED state
SyncErr  output  1  one-cycle pulse: sync violation detected

Behaviour:
- Interface (decided): one clock, Clock. Reset Resetn is asynchronous and active-low.
- Reset state: state=HUNT; Sel=0; Q=0; shadow bank=0; FrameValid=0; Locked=0; SyncErr=0.
- All outputs are registered. Cycles with En=0 change nothing except clearing the pulse outputs.
- State HUNT:
  - En=1 and Sync=0: word discarded; stay in HUNT.
  - En=1 and Sync=1: shadow[0] <= Din; Sel <= 1; go to LOCKED.
- State LOCKED, En=1, Sync=0, Sel!=0: shadow[Sel] <= Din; Sel <= Sel+1, wrapping mod N.
- State LOCKED, slot N-1 accepted (Sel==N-1, Sync=0):
  - At the same edge, Q <= {Din, shadow[N-2..0]}.
  - FrameValid=1 for the following cycle; Sel <= 0.
  - Latency: Q reflects the last word one edge after its capture.
- State LOCKED, Sel==0, En=1, Sync=1: normal frame start; shadow[0] <= Din; Sel <= 1.
- State LOCKED, Sel==0, En=1, Sync=0 (missing sync):
  - SyncErr pulse; word discarded.
  - Go to HUNT; Sel <= 0; Q unchanged.
- State LOCKED, Sel!=0, En=1, Sync=1 (early sync):
  - SyncErr pulse; the partial frame is abandoned and never published.
  - Resync: word treated as channel 0; shadow[0] <= Din; Sel <= 1; stay in LOCKED.
- Degenerate case N=1 (SELW=0) is not supported; SELW>=1 is required.
- Q holds its last published frame until the next complete frame. Q never shows a mix of two frames.
- Resetn asserted mid-frame: immediate return to reset state; the partial frame is lost.
- Sync with En=0 is ignored.

Optional Feature:
- Macro: TDM_PARITY_EN.
- When defined:
  - Extra input port Par (1 bit): odd parity over Din, qualified by En.
  - Extra output ParErr (1 bit): one-cycle pulse on any parity mismatch.
  - A frame containing any mismatched word is not published: Q is unchanged and FrameValid is not raised. The slot sequence and lock state are unaffected.
  - The per-frame error flag clears at each channel-0 accept.
- When undefined: no Par/ParErr ports; parity is not checked.

Test Plan:
All scenarios use SELW=2, W=8.
- Reset, then En=1 with Sync=1 on 0x11, then 0x22, 0x33, 0x44 on consecutive cycles -> Q=0x44332211 one edge after 0x44; FrameValid high for exactly 1 cycle; Locked=1; Sel=0.
- In HUNT, words 0xAA and 0xBB with Sync=0, then the frame from scenario 1 -> 0xAA and 0xBB ignored; Q=0x44332211.
- Locked, frame 0x01,0x02 (slot 2 stalls with En=0 for 3 cycles),0x03,0x04 -> Q=0x04030201; no FrameValid before the fourth word.
- Locked, 0x10,0x20, then Sync=1 on 0x30, then 0x40,0x50,0x60 -> SyncErr pulse on the resync word; Q=0x60504030; the previous Q is retained until then.
- Locked at Sel=0, En=1 with Sync=0 -> SyncErr pulse; Locked=0; Q unchanged.
- Resetn pulsed low asynchronously after 2 words -> Q=0, Sel=0, Locked=0 immediately, without waiting for a Clock edge. With TDM_PARITY_EN, a bad Par on slot 1 -> ParErr pulse; frame not published.
